gnrc_gray_cnt: RTL and testbench
================================

Name: gnrc_gray_cnt

Overview:
- N-bit binary counter whose state is also held as registered Gray code; this is the encode-side companion of the Gray-to-binary converter.
- Intended use: async-FIFO write/read pointers and clock-domain-crossing counters. gray_o comes directly from flops, so it is glitch-free and changes exactly one bit per count step.
- Supports up/down counting, synchronous clear, parallel load and a wrap indication.
- gray_next_o is a look-ahead output for registered full/empty comparison in FIFOs.

Parameters:
- N, 8, counter width in bits; range >=1.
- RST_VAL, 0, binary value loaded on reset and on clr_i; must satisfy 0 <= RST_VAL <= 2^N-1.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  synchronous reset, active-high.
- clr_i  input  1  synchronous clear to RST_VAL.
- en_i  input  1  count enable; one step per cycle while high.
- dir_i  input  1  count direction: 1 = up (+1), 0 = down (-1).
- load_i  input  1  parallel load strobe.
- load_bin_i  input  N  binary value to load.
- bin_o  output  N  current count, binary, registered.
- gray_o  output  N  current count, Gray code, registered.
- gray_next_o  output  N  Gray code of the value bin_o/gray_o will take after the next edge; combinational.
- wrap_o  output  1  registered one-cycle pulse, set on the cycle after a count step crossed the modulus boundary.

Behaviour:
- Interface (already decided): one clock, clk_i; reset rst_i is synchronous and active-high.
- Reset (rst_i=1 at an edge):
  - bin_o = RST_VAL.
  - gray_o = RST_VAL ^ (RST_VAL >> 1).
  - wrap_o = 0.
  - rst_i overrides all other inputs.
- Next-state priority per edge: rst_i > clr_i > load_i > en_i > hold.
  - clr_i: bin = RST_VAL; wrap_o = 0.
  - load_i: bin = load_bin_i; wrap_o = 0. A load never produces a wrap pulse, even when en_i=1 in the same cycle.
  - en_i & dir_i: bin = bin + 1 mod 2^N. wrap_o = 1 if the old bin was 2^N-1, else 0.
  - en_i & !dir_i: bin = bin - 1 mod 2^N. wrap_o = 1 if the old bin was 0, else 0.
  - none of the above: hold bin; wrap_o = 0.
- Gray state:
  - Held in its own N-bit register.
  - Written every edge with gray(bin_next), where gray(x) = x ^ (x >> 1).
  - Never derived combinationally from bin_o at the output, so gray_o is directly flop-driven.
- Invariant after every edge: gray_o == gray(bin_o).
- Single-bit change rule: on any count step, including wrap in either direction, gray_o changes exactly one bit. Loads and clears may change any number of bits.
- gray_next_o:
  - Equals gray(bin_next) computed from the current inputs and state.
  - Equals gray_o when nothing is active.
  - Zero-cycle path from clr_i/load_i/en_i/dir_i/load_bin_i.
- Latency: one cycle from an input to bin_o/gray_o/wrap_o.
- N=1: the counter toggles 0<->1 on every step; every step wraps; Gray equals binary.
- dir_i is ignored unless en_i=1 and load_i=0.

Decomposition:
- Shared package gnrc_codec_pkg holds pure functions:
  - bin2gray(x): N-generic via a width parameter, or a max-width function with slicing.
  - gray2bin(x): prefix XOR, for benches and reuse.
- Sub-module gnrc_bin2gray:
  - Parameter N.
  - Ports bin_i -> gray_o; purely combinational: gray_o[i] = bin_i[i] ^ bin_i[i+1], and gray_o[N-1] = bin_i[N-1].
  - Instantiated once on bin_next to feed both the Gray register and gray_next_o.
- Counter, priority mux and wrap detect live in gnrc_gray_cnt.

Test Plan:
- Reset and full-cycle up count, N=4, RST_VAL=0:
  - Stimulus: assert rst_i, release, hold en_i=1, dir_i=1 for 16 cycles.
  - Response: bin_o runs 0..15 then 0; gray_o runs 0000,0001,0011,0010,0110,...,1000,0000.
  - Hamming distance between consecutive gray_o values is 1; wrap_o pulses only on the cycle bin_o returns to 0.
- Down wrap, N=4:
  - Stimulus: from bin_o=0, en_i=1, dir_i=0.
  - Response: next cycle bin_o=15, gray_o=1000, wrap_o=1; following cycle bin_o=14, gray_o=1001, wrap_o=0.
- Load priority, N=8:
  - Stimulus: load_i=1, load_bin_i=0xB5, en_i=1, dir_i=1.
  - Response: bin_o=0xB5, gray_o=0xEF, wrap_o=0.
  - gray_next_o shows 0xEF in the same cycle load_i is high.
- Clear over load, N=8:
  - Stimulus: clr_i=1 and load_i=1 together.
  - Response: bin_o=RST_VAL.
  - With RST_VAL=0x10 this gives gray_o=0x18.
- Reset mid-count, N=4:
  - Stimulus: counting up at bin_o=7, assert rst_i for one cycle with en_i=1 still high.
  - Response: bin_o=0, gray_o=0, wrap_o=0; counting resumes at 1 on the following edge.
- Random soak, N=1/5/8:
  - Stimulus: 10k cycles of random clr/load/en/dir.
  - Response: gray_o == gray(bin_o) every cycle.
  - gray2bin(gray_o) == bin_o.
  - gray_next_o equals the next-cycle gray_o.
  - Each count step changes exactly one gray_o bit.

Source files
------------

// File: rtl/gnrc_codec_pkg.sv
// Shared Gray/binary conversion helpers. Functions work on a 32-bit container;
// narrower callers zero-extend and slice the result.
package gnrc_codec_pkg;

  function automatic logic [31:0] bin2gray(input logic [31:0] x);
    return x ^ (x >> 1);
  endfunction

  // Prefix XOR from the MSB down; zero-extended upper bits leave the low bits intact.
  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/gnrc_bin2gray.sv
// Purely combinational N-bit binary-to-Gray encoder.
module gnrc_bin2gray #(
  parameter int N = 8
) (
  input  logic [N-1:0] bin_i,
  output logic [N-1:0] gray_o
);

  for (genvar i = 0; i < N - 1; i++) begin : g_bit
    assign gray_o[i] = bin_i[i] ^ bin_i[i+1];
  end

  assign gray_o[N-1] = bin_i[N-1];

endmodule

// File: rtl/gnrc_gray_cnt.sv
// Up/down binary counter with a separately registered Gray copy, so gray_o is
// flop-driven and safe to hand across clock domains.
module gnrc_gray_cnt
  import gnrc_codec_pkg::*;
#(
  parameter int N       = 8,
  parameter int RST_VAL = 0
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic         dir_i,
  input  logic         load_i,
  input  logic [N-1:0] load_bin_i,
  output logic [N-1:0] bin_o,
  output logic [N-1:0] gray_o,
  output logic [N-1:0] gray_next_o,
  output logic         wrap_o
);

  localparam logic [N-1:0] RstBin  = N'(RST_VAL);
  localparam logic [N-1:0] RstGray = N'(bin2gray(32'(RST_VAL)));
  localparam logic [N-1:0] MaxBin  = '1;

  logic [N-1:0] binQ;
  logic [N-1:0] grayQ;
  logic         wrapQ;
  logic [N-1:0] binNext;
  logic [N-1:0] grayNext;
  logic         wrapNext;

  // Reset is folded into the mux too, so gray_next_o always predicts the next gray_o.
  always_comb begin
    binNext  = binQ;
    wrapNext = 1'b0;
    if (rst_i) begin
      binNext = RstBin;
    end else if (clr_i) begin
      binNext = RstBin;
    end else if (load_i) begin
      binNext = load_bin_i;
    end else if (en_i) begin
      if (dir_i) begin
        binNext  = binQ + 1'b1;
        wrapNext = (binQ == MaxBin);
      end else begin
        binNext  = binQ - 1'b1;
        wrapNext = (binQ == '0);
      end
    end
  end

  gnrc_bin2gray #(
    .N(N)
  ) u_bin2gray (
    .bin_i (binNext),
    .gray_o(grayNext)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      binQ  <= RstBin;
      grayQ <= RstGray;
      wrapQ <= 1'b0;
    end else begin
      binQ  <= binNext;
      grayQ <= grayNext;
      wrapQ <= wrapNext;
    end
  end

  assign bin_o       = binQ;
  assign gray_o      = grayQ;
  assign wrap_o      = wrapQ;
  assign gray_next_o = grayNext;

endmodule

// File: tb/tb_gnrc_gray_cnt.sv
// Directed and random checks of gnrc_gray_cnt at widths 1, 4, 5 and 8 sharing
// one set of inputs; each instance is compared against its own bench model.
module tb_gnrc_gray_cnt;
  import gnrc_codec_pkg::*;

  logic       clk = 1'b0;
  logic       rst, clr, en, dir, load;
  logic [7:0] loadBin;

  logic [0:0] bin1, gray1, grayNext1;
  logic [3:0] bin4, gray4, grayNext4;
  logic [4:0] bin5, gray5, grayNext5;
  logic [7:0] bin8, gray8, grayNext8;
  logic       wrap1, wrap4, wrap5, wrap8;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  gnrc_gray_cnt #(.N(1), .RST_VAL(0)) dut1 (
    .clk_i(clk), .rst_i(rst), .clr_i(clr), .en_i(en), .dir_i(dir), .load_i(load),
    .load_bin_i(loadBin[0:0]), .bin_o(bin1), .gray_o(gray1), .gray_next_o(grayNext1),
    .wrap_o(wrap1));
  gnrc_gray_cnt #(.N(4), .RST_VAL(0)) dut4 (
    .clk_i(clk), .rst_i(rst), .clr_i(clr), .en_i(en), .dir_i(dir), .load_i(load),
    .load_bin_i(loadBin[3:0]), .bin_o(bin4), .gray_o(gray4), .gray_next_o(grayNext4),
    .wrap_o(wrap4));
  gnrc_gray_cnt #(.N(5), .RST_VAL(3)) dut5 (
    .clk_i(clk), .rst_i(rst), .clr_i(clr), .en_i(en), .dir_i(dir), .load_i(load),
    .load_bin_i(loadBin[4:0]), .bin_o(bin5), .gray_o(gray5), .gray_next_o(grayNext5),
    .wrap_o(wrap5));
  gnrc_gray_cnt #(.N(8), .RST_VAL(16)) dut8 (
    .clk_i(clk), .rst_i(rst), .clr_i(clr), .en_i(en), .dir_i(dir), .load_i(load),
    .load_bin_i(loadBin), .bin_o(bin8), .gray_o(gray8), .gray_next_o(grayNext8),
    .wrap_o(wrap8));

  // Index 0..3 maps to the N=1, 4, 5, 8 instances.
  logic [7:0] obsBin[4], obsGray[4], obsGrayNext[4];
  logic       obsWrap[4];
  assign obsBin[0] = 8'(bin1);  assign obsGray[0] = 8'(gray1);  assign obsGrayNext[0] = 8'(grayNext1);
  assign obsBin[1] = 8'(bin4);  assign obsGray[1] = 8'(gray4);  assign obsGrayNext[1] = 8'(grayNext4);
  assign obsBin[2] = 8'(bin5);  assign obsGray[2] = 8'(gray5);  assign obsGrayNext[2] = 8'(grayNext5);
  assign obsBin[3] = bin8;      assign obsGray[3] = gray8;      assign obsGrayNext[3] = grayNext8;
  assign obsWrap[0] = wrap1; assign obsWrap[1] = wrap4; assign obsWrap[2] = wrap5; assign obsWrap[3] = wrap8;

  int widthOf[4]  = '{1, 4, 5, 8};
  int rstValOf[4] = '{0, 0, 3, 16};

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic c, input logic l, input logic [7:0] lb,
                               input logic e, input logic d);
    rst = r; clr = c; load = l; loadBin = lb; en = e; dir = d;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Independent reference: next binary value and wrap flag for one instance.
  function automatic logic [8:0] modelStep(input int n, input int rv, input logic [7:0] cur);
    logic [7:0] mask;
    logic [7:0] nxt;
    logic       w;
    mask = 8'((1 << n) - 1);
    nxt  = cur;
    w    = 1'b0;
    if (rst || clr)  nxt = 8'(rv);
    else if (load)   nxt = loadBin & mask;
    else if (en) begin
      if (dir) begin w = (cur == mask); nxt = (cur + 8'd1) & mask; end
      else     begin w = (cur == 8'd0); nxt = (cur - 8'd1) & mask; end
    end
    return {w, nxt};
  endfunction

  logic [3:0] grayTab[16] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                              4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};

  initial begin
    logic [3:0] prevGray;
    logic [7:0] modelBin[4];
    logic [7:0] nextBin[4];
    logic       nextWrap[4];
    logic [7:0] prevGrays[4];
    logic       isStep;
    logic [8:0] res;

    // Reset, then a full up cycle on N=4
    applyStimulus(1, 0, 0, 8'h00, 0, 1);
    tick();
    checkOutput("rst_bin4", 32'(bin4), 32'h0);
    checkOutput("rst_gray4", 32'(gray4), 32'h0);
    checkOutput("rst_wrap4", 32'(wrap4), 32'h0);
    checkOutput("rst_bin8", 32'(bin8), 32'h10);
    checkOutput("rst_gray8", 32'(gray8), 32'h18);
    checkOutput("rst_gray5", 32'(gray5), 32'h2);

    applyStimulus(0, 0, 0, 8'h00, 1, 1);
    for (int i = 1; i <= 16; i++) begin
      prevGray = gray4;
      checkOutput("up_gnext4", 32'(grayNext4), 32'(grayTab[i % 16]));
      tick();
      checkOutput("up_bin4", 32'(bin4), 32'(i % 16));
      checkOutput("up_gray4", 32'(gray4), 32'(grayTab[i % 16]));
      checkOutput("up_wrap4", 32'(wrap4), (i == 16) ? 32'h1 : 32'h0);
      checkOutput("up_hamming4", 32'($countones(prevGray ^ gray4)), 32'h1);
    end

    // Down wrap from 0
    applyStimulus(0, 0, 0, 8'h00, 1, 0);
    tick();
    checkOutput("dn_bin4", 32'(bin4), 32'hF);
    checkOutput("dn_gray4", 32'(gray4), 32'h8);
    checkOutput("dn_wrap4", 32'(wrap4), 32'h1);
    tick();
    checkOutput("dn2_bin4", 32'(bin4), 32'hE);
    checkOutput("dn2_gray4", 32'(gray4), 32'h9);
    checkOutput("dn2_wrap4", 32'(wrap4), 32'h0);

    // Load beats count enable
    applyStimulus(0, 0, 1, 8'hB5, 1, 1);
    checkOutput("ld_gnext8", 32'(grayNext8), 32'hEF);
    tick();
    checkOutput("ld_bin8", 32'(bin8), 32'hB5);
    checkOutput("ld_gray8", 32'(gray8), 32'hEF);
    checkOutput("ld_wrap8", 32'(wrap8), 32'h0);

    // Load of all-ones with en still high must not pulse wrap on the next up-step's load
    applyStimulus(0, 0, 1, 8'hFF, 1, 1);
    tick();
    checkOutput("ldmax_wrap8", 32'(wrap8), 32'h0);
    applyStimulus(0, 0, 0, 8'h00, 1, 1);
    tick();
    checkOutput("wrapmax_bin8", 32'(bin8), 32'h00);
    checkOutput("wrapmax_wrap8", 32'(wrap8), 32'h1);

    // Clear beats load
    applyStimulus(0, 1, 1, 8'hB5, 1, 1);
    checkOutput("clr_gnext8", 32'(grayNext8), 32'h18);
    tick();
    checkOutput("clr_bin8", 32'(bin8), 32'h10);
    checkOutput("clr_gray8", 32'(gray8), 32'h18);
    checkOutput("clr_wrap8", 32'(wrap8), 32'h0);

    // Hold: nothing active, gray_next equals gray
    applyStimulus(0, 0, 0, 8'h00, 0, 1);
    checkOutput("hold_gnext8", 32'(grayNext8), 32'h18);
    tick();
    checkOutput("hold_bin8", 32'(bin8), 32'h10);

    // Reset mid-count on N=4
    applyStimulus(1, 0, 0, 8'h00, 0, 1);
    tick();
    applyStimulus(0, 0, 0, 8'h00, 1, 1);
    repeat (7) tick();
    checkOutput("mid_bin4", 32'(bin4), 32'h7);
    applyStimulus(1, 0, 0, 8'h00, 1, 1);
    checkOutput("mid_gnext4", 32'(grayNext4), 32'h0);
    tick();
    checkOutput("midrst_bin4", 32'(bin4), 32'h0);
    checkOutput("midrst_gray4", 32'(gray4), 32'h0);
    checkOutput("midrst_wrap4", 32'(wrap4), 32'h0);
    applyStimulus(0, 0, 0, 8'h00, 1, 1);
    tick();
    checkOutput("resume_bin4", 32'(bin4), 32'h1);
    checkOutput("resume_gray4", 32'(gray4), 32'h1);

    // Random soak on all widths against the model
    applyStimulus(1, 0, 0, 8'h00, 0, 1);
    tick();
    for (int k = 0; k < 4; k++) modelBin[k] = 8'(rstValOf[k]);
    for (int cyc = 0; cyc < 10000; cyc++) begin
      applyStimulus(($urandom_range(63) == 0), ($urandom_range(15) == 0), ($urandom_range(7) == 0),
                    8'($urandom), ($urandom_range(3) != 0), 1'($urandom));
      isStep = !rst && !clr && !load && en;
      for (int k = 0; k < 4; k++) begin
        res         = modelStep(widthOf[k], rstValOf[k], modelBin[k]);
        nextBin[k]  = res[7:0];
        nextWrap[k] = res[8];
        prevGrays[k] = obsGray[k];
        checkOutput("soak_gnext", 32'(obsGrayNext[k]), bin2gray(32'(nextBin[k])));
      end
      tick();
      for (int k = 0; k < 4; k++) begin
        modelBin[k] = nextBin[k];
        checkOutput("soak_bin", 32'(obsBin[k]), 32'(nextBin[k]));
        checkOutput("soak_gray", 32'(obsGray[k]), bin2gray(32'(nextBin[k])));
        checkOutput("soak_g2b", gray2bin(32'(obsGray[k])), 32'(nextBin[k]));
        checkOutput("soak_wrap", 32'(obsWrap[k]), 32'(nextWrap[k]));
        if (isStep)
          checkOutput("soak_hamming", 32'($countones(prevGrays[k] ^ obsGray[k])), 32'h1);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
